// File: rtl/gpio_link_pkg.sv
// Shared definitions for the conv/MCU GPIO command link: command bit positions, sequencer states, bus widths.
// The slave side imports the same package so both ends agree on the bit map.
package gpio_link_pkg;

  localparam int GPIO_D_DEFAULT    = 32;
  localparam int BITS_DATA_DEFAULT = 13;

  localparam int CMD_RST   = 0;
  localparam int CMD_START = 1;
  localparam int CMD_NEXT  = 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_HI,
    S_RST_LO,
    S_START_HI,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_READ,
    S_NXT_HI,
    S_NXT_LO,
    S_FINISH,
    S_ERR
  } link_state_t;

endpackage

// File: rtl/gpio_pulse_gen.sv
// Loadable down-counter giving a PULSE_CYC-wide level; o_last marks the final high cycle.
// Level rises the cycle after i_load; a new load restarts the count.
module gpio_pulse_gen #(
  parameter int PULSE_CYC = 2
) (
  input  logic CLK100MHZ,
  input  logic i_reset,
  input  logic i_load,
  output logic o_level,
  output logic o_last
);

  localparam int W = $clog2(PULSE_CYC + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(PULSE_CYC);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) begin
      cnt <= '0;
    end else if (i_load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign o_level = (cnt != '0);
  assign o_last  = (cnt == W'(1));

endmodule

// File: rtl/gpio_host_seq.sv
// Hardware host for the conv/MCU GPIO link: reset/start the slave, wait for done, then step out result words.
// All outputs are registered decodes of the current state (one cycle behind it); the slave has no backpressure path.
module gpio_host_seq
  import gpio_link_pkg::*;
#(
  parameter int GPIO_D     = GPIO_D_DEFAULT,
  parameter int BITS_DATA  = BITS_DATA_DEFAULT,
  parameter int NB_ADDRESS = 4,
  parameter int RST_CYC    = 4,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 3,
  parameter int TMO_CYC    = 1024
) (
  input  logic                  CLK100MHZ,
  input  logic                  i_reset,
  input  logic                  i_go,
  input  logic                  i_abort,
  input  logic [NB_ADDRESS-1:0] i_num_words,
  input  logic [GPIO_D-1:0]     i_gpio_data,
  input  logic                  i_done,
  output logic [GPIO_D-1:0]     o_gpio_cmd,
  output logic [BITS_DATA-1:0]  o_rd_data,
  output logic [NB_ADDRESS-1:0] o_rd_idx,
  output logic                  o_rd_valid,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_timeout
);

  localparam int CW = $clog2(TMO_CYC + 1);

  link_state_t           state, state_nx;
  logic [CW-1:0]         dwell;
  logic [NB_ADDRESS-1:0] num_q, k_q;
  logic [GPIO_D-1:0]     cmd_nx;
  logic                  pulse_load, pulse_level, pulse_last;
  logic                  restart, go_ok, settle_hit, tmo_hit;
  logic                  unused_hi;

  assign unused_hi  = ^i_gpio_data[GPIO_D-1:BITS_DATA];
  assign restart    = i_abort && (state != S_IDLE);
  assign go_ok      = (state == S_IDLE) && i_go;
  assign settle_hit = (dwell == CW'(SETTLE_CYC - 1));
  assign tmo_hit    = (dwell == CW'(TMO_CYC - 1));

  gpio_pulse_gen #(.PULSE_CYC(PULSE_CYC)) u_pulse (
    .CLK100MHZ (CLK100MHZ),
    .i_reset   (i_reset),
    .i_load    (pulse_load),
    .o_level   (pulse_level),
    .o_last    (pulse_last)
  );

  always_comb begin
    state_nx   = state;
    pulse_load = 1'b0;
    unique case (state)
      S_IDLE:      if (i_go) state_nx = S_RST_HI;
      S_RST_HI:    if (dwell == CW'(RST_CYC - 1)) state_nx = S_RST_LO;
      S_RST_LO:    if (dwell == CW'(1)) state_nx = S_START_HI;
      S_START_HI:  if (pulse_last) state_nx = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!i_done)      state_nx = S_WAIT_DONE;
        else if (tmo_hit) state_nx = S_ERR;
      end
      S_WAIT_DONE: begin
        if (i_done)       state_nx = (num_q == '0) ? S_FINISH : S_READ;
        else if (tmo_hit) state_nx = S_ERR;
      end
      S_READ:      if (settle_hit) state_nx = (k_q == num_q - 1'b1) ? S_FINISH : S_NXT_HI;
      S_NXT_HI:    if (pulse_last) state_nx = S_NXT_LO;
      S_NXT_LO:    state_nx = S_READ;
      S_FINISH:    state_nx = S_IDLE;
      S_ERR:       state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
    // Abort overrides everything, including a timeout landing on the same cycle.
    if (restart) state_nx = S_RST_HI;
    pulse_load = (state_nx != state) && (state_nx == S_START_HI || state_nx == S_NXT_HI);
  end

  always_comb begin
    cmd_nx = '0;
    unique case (state)
      S_IDLE, S_RST_HI, S_ERR: cmd_nx[CMD_RST]   = 1'b1;
      S_START_HI:              cmd_nx[CMD_START] = pulse_level;
      S_NXT_HI:                cmd_nx[CMD_NEXT]  = pulse_level;
      default:                 cmd_nx = '0;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) begin
      state        <= S_IDLE;
      dwell        <= '0;
      num_q        <= '0;
      k_q          <= '0;
      o_gpio_cmd   <= {{(GPIO_D-1){1'b0}}, 1'b1};
      o_rd_data    <= '0;
      o_rd_idx     <= '0;
      o_rd_valid   <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      state <= state_nx;
      // One dwell counter serves the fixed holds, the settle wait and the ack/done timeout.
      dwell <= ((state_nx != state) || restart) ? '0 : dwell + 1'b1;

      if (go_ok) num_q <= i_num_words;

      if (go_ok || restart)      k_q <= '0;
      else if (state == S_NXT_LO) k_q <= k_q + 1'b1;

      o_gpio_cmd   <= cmd_nx;
      o_busy       <= (state != S_IDLE);
      o_frame_done <= (state == S_FINISH) && !restart;
      o_rd_valid   <= (state == S_READ) && settle_hit && !restart;
      if ((state == S_READ) && settle_hit && !restart) begin
        o_rd_data <= i_gpio_data[BITS_DATA-1:0];
        o_rd_idx  <= k_q;
      end

      if (go_ok)                                o_timeout <= 1'b0;
      else if ((state == S_ERR) && !restart)    o_timeout <= 1'b1;
    end
  end

endmodule
